// File: rtl/calc_hist.sv
// WIDTH-bit signed accumulator calculator with a two-cycle execute pipeline,
// button edge detection, a circular undo history and sticky overflow/zero status.
module calc_hist #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       btnac,
  input  logic                       btnc,
  input  logic                       btnu,
  input  logic                       btnl,
  input  logic                       btnr,
  input  logic                       btnd,
  input  logic [WIDTH-1:0]           sw,
  output logic [WIDTH-1:0]           led,
  output logic                       ovf_led,
  output logic                       zero_led,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] hist_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    OpLsr  = 3'b000,
    OpLsl  = 3'b001,
    OpAdd  = 3'b010,
    OpSub  = 3'b011,
    OpMul  = 3'b100,
    OpNor  = 3'b101,
    OpNand = 3'b110,
    OpXor  = 3'b111
  } op_e;

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  function automatic op_e calc_enc(input logic l, input logic r, input logic d);
    op_e op;
    unique case ({l, r, d})
      3'b000:  op = OpLsr;
      3'b001:  op = OpLsl;
      3'b010:  op = OpAdd;
      3'b011:  op = OpSub;
      3'b100:  op = OpMul;
      3'b101:  op = OpNor;
      3'b110:  op = OpNand;
      default: op = OpXor;
    endcase
    return op;
  endfunction

  state_e                state_q, state_d;
  logic                  btnc_q, btnu_q;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  op_e                   op_q, op_d;
  logic signed [31:0]    a_q, a_d, b_q, b_d;
  logic [PtrW-1:0]       wp_q, wp_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]      hist_mem [DEPTH];
  logic                  push;

  logic                  c_edge, u_edge;
  logic signed [WIDTH-1:0] acc_s, sw_s;
  logic [PtrW-1:0]       wp_inc, wp_dec;

  assign c_edge = btnc & ~btnc_q;
  assign u_edge = btnu & ~btnu_q;
  assign acc_s  = acc_q;
  assign sw_s   = sw;
  assign wp_inc = (wp_q == PtrW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
  assign wp_dec = (wp_q == '0) ? PtrW'(DEPTH - 1) : wp_q - 1'b1;

  // ALU: purely combinational between the operand registers and the writeback.
  logic [31:0]        res;
  logic               alu_ovf;
  logic signed [31:0] sum, diff;
  logic signed [63:0] prod;
  logic [32-WIDTH:0]  res_hi;
  logic               fits;

  always_comb begin
    sum     = a_q + b_q;
    diff    = a_q - b_q;
    prod    = 64'(a_q) * 64'(b_q);
    res     = '0;
    alu_ovf = 1'b0;
    unique case (op_q)
      OpLsr:  res = 32'(a_q) >> b_q[4:0];
      OpLsl:  res = 32'(a_q) << b_q[4:0];
      OpAdd: begin
        res     = sum;
        alu_ovf = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
      end
      OpSub: begin
        res     = diff;
        alu_ovf = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
      end
      OpMul: begin
        res     = prod[31:0];
        alu_ovf = !((&prod[63:31]) || !(|prod[63:31]));
      end
      OpNor:  res = ~(a_q | b_q);
      OpNand: res = ~(a_q & b_q);
      OpXor:  res = a_q ^ b_q;
      default: res = '0;
    endcase
    res_hi = res[31:WIDTH-1];
    fits   = (&res_hi) | ~(|res_hi);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (c_edge) begin
          op_d    = calc_enc(btnl, btnr, btnd);
          a_d     = 32'(acc_s);
          b_d     = 32'(sw_s);
          push    = 1'b1;
          wp_d    = wp_inc;
          cnt_d   = (cnt_q == CntW'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
          state_d = StExec;
        end else if (u_edge && (cnt_q != '0)) begin
          acc_d = hist_mem[wp_dec];
          wp_d  = wp_dec;
          cnt_d = cnt_q - 1'b1;
        end
      end
      StExec: begin
        acc_d   = res[WIDTH-1:0];
        ovf_d   = ovf_q | alu_ovf | ~fits;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge btnac) begin
    if (btnac) begin
      state_q <= StIdle;
      btnc_q  <= 1'b0;
      btnu_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      op_q    <= OpLsr;
      a_q     <= '0;
      b_q     <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      btnc_q  <= btnc;
      btnu_q  <= btnu;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
    end
  end

  // History storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      hist_mem[wp_q] <= acc_q;
    end
  end

  assign led      = acc_q;
  assign ovf_led  = ovf_q;
  assign zero_led = (acc_q == '0);
  assign busy     = (state_q == StExec);
  assign hist_cnt = cnt_q;

endmodule

// File: tb/tb_calc_hist.sv
// Directed bench for calc_hist: executes are scored by a monitor on busy falling;
// undo, reset and edge-rule behaviour are checked directly.
module tb_calc_hist;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         btnac = 1'b0;
  logic         btnc = 1'b0, btnu = 1'b0;
  logic         btnl = 1'b0, btnr = 1'b0, btnd = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] led;
  logic         ovf_led, zero_led, busy;
  logic [2:0]   hist_cnt;

  calc_hist #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .btnac    (btnac),
    .btnc     (btnc),
    .btnu     (btnu),
    .btnl     (btnl),
    .btnr     (btnr),
    .btnd     (btnd),
    .sw       (sw),
    .led      (led),
    .ovf_led  (ovf_led),
    .zero_led (zero_led),
    .busy     (busy),
    .hist_cnt (hist_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] led;
    logic         ovf;
    logic         zero;
    logic [2:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every execute writeback shows up as busy falling.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge btnac);
      if (btnac) begin
        busy_prev = 1'b0;
      end else begin
        if (busy_prev && !busy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_writeback", 32'(led), 32'hdead_beef);
          end else begin
            e = exp_q.pop_front();
            chk("exec_led", 32'(led), 32'(e.led));
            chk("exec_ovf", 32'(ovf_led), 32'(e.ovf));
            chk("exec_zero", 32'(zero_led), 32'(e.zero));
            chk("exec_cnt", 32'(hist_cnt), 32'(e.cnt));
          end
        end
        busy_prev = busy;
      end
    end
  end

  task automatic expect_exec(input logic [W-1:0] l, input logic o, input logic [2:0] c);
    exp_t e;
    e.led  = l;
    e.ovf  = o;
    e.zero = (l == '0);
    e.cnt  = c;
    exp_q.push_back(e);
  endtask

  task automatic do_exec(input logic [2:0] op, input logic [W-1:0] v, input logic with_u,
                         input logic [W-1:0] l, input logic o, input logic [2:0] c);
    {btnl, btnr, btnd} = op;
    sw   = v;
    btnc = 1'b1;
    btnu = with_u;
    expect_exec(l, o, c);
    tick();
    btnc = 1'b0;
    btnu = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_undo(input logic [W-1:0] l, input logic [2:0] c);
    btnu = 1'b1;
    tick();
    chk("undo_led", 32'(led), 32'(l));
    chk("undo_cnt", 32'(hist_cnt), 32'(c));
    btnu = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    btnac = 1'b1;
    tick();
    btnac = 1'b0;
    tick();
  endtask

  initial begin
    #1 btnac = 1'b1;
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_zero", 32'(zero_led), 32'h1);
    chk("rst_ovf", 32'(ovf_led), 32'h0);
    chk("rst_cnt", 32'(hist_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    tick();
    btnac = 1'b0;
    tick();

    // ADD 5 then SUB 7
    do_exec(3'b010, 16'd5, 1'b0, 16'h0005, 1'b0, 3'd1);
    do_exec(3'b011, 16'd7, 1'b0, 16'hfffe, 1'b0, 3'd2);

    // Asynchronous reset mid-cycle
    #1 btnac = 1'b1;
    #1;
    chk("async_led", 32'(led), 32'h0);
    chk("async_zero", 32'(zero_led), 32'h1);
    chk("async_ovf", 32'(ovf_led), 32'h0);
    chk("async_cnt", 32'(hist_cnt), 32'h0);
    #1 btnac = 1'b0;
    tick();

    // MUL overflow, sticky across a later ADD
    do_exec(3'b010, 16'h0100, 1'b0, 16'h0100, 1'b0, 3'd1);
    do_exec(3'b100, 16'h0100, 1'b0, 16'h0000, 1'b1, 3'd2);
    do_exec(3'b010, 16'h0001, 1'b0, 16'h0001, 1'b1, 3'd3);

    // History wrap: five pushes into four entries, then drain
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      do_exec(3'b010, 16'd1, 1'b0, W'(i), 1'b0, (i > 4) ? 3'd4 : 3'(i));
    end
    do_undo(16'd4, 3'd3);
    do_undo(16'd3, 3'd2);
    do_undo(16'd2, 3'd1);
    do_undo(16'd1, 3'd0);
    do_undo(16'd1, 3'd0);
    chk("undo_keeps_ovf", 32'(ovf_led), 32'h0);

    // Held btnc gives exactly one execute (a second writeback would be unexpected)
    {btnl, btnr, btnd} = 3'b010;
    sw   = 16'd2;
    btnc = 1'b1;
    expect_exec(16'd3, 1'b0, 3'd1);
    repeat (10) tick();
    btnc = 1'b0;
    tick();
    tick();
    chk("hold_led", 32'(led), 32'd3);
    chk("hold_cnt", 32'(hist_cnt), 32'd1);

    // Simultaneous btnc/btnu: execute wins
    do_exec(3'b010, 16'd1, 1'b1, 16'd4, 1'b0, 3'd2);

    // btnu while busy is dropped
    {btnl, btnr, btnd} = 3'b010;
    sw   = 16'd1;
    btnc = 1'b1;
    expect_exec(16'd5, 1'b0, 3'd3);
    tick();
    chk("busy_set", 32'(busy), 32'h1);
    btnc = 1'b0;
    btnu = 1'b1;
    tick();
    btnu = 1'b0;
    tick();
    tick();
    chk("busy_undo_led", 32'(led), 32'd5);
    chk("busy_undo_cnt", 32'(hist_cnt), 32'd3);

    // Reset during EXEC aborts writeback
    {btnl, btnr, btnd} = 3'b010;
    sw   = 16'd10;
    btnc = 1'b1;
    tick();
    btnc = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'h1);
    #1 btnac = 1'b1;
    #1;
    chk("abort_led_in_rst", 32'(led), 32'h0);
    #1 btnac = 1'b0;
    tick();
    tick();
    chk("abort_led", 32'(led), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_cnt", 32'(hist_cnt), 32'h0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
